// File: rtl/reaction_bcd_timer.sv
// Reaction-time counter: counts ms ticks as packed BCD while the stimulus is lit,
// freezes on stop and keeps the best non-overflowed result since reset.
module reaction_bcd_timer #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned DIV_W    = 16
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        run_i,
  input  logic        stop_i,
  input  logic        clear_i,
  output logic [15:0] bcd_o,
  output logic        counting_o,
  output logic        done_o,
  output logic        overflow_o,
  output logic [15:0] best_bcd_o,
  output logic        new_best_o
);

  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_e;

  localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [15:0]      best_q, best_d;
  logic             best_valid_q, best_valid_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             new_best_q, new_best_d;
  logic             counting_q, counting_d;
  logic             tick;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign tick = (presc_q == TICK_LAST);

  always_comb begin
    state_d      = state_q;
    presc_d      = '0;
    bcd_d        = bcd_q;
    ovf_d        = ovf_q;
    best_d       = best_q;
    best_valid_d = best_valid_q;
    done_d       = 1'b0;
    new_best_d   = 1'b0;
    case (state_q)
      IDLE: begin
        bcd_d = '0;
        ovf_d = 1'b0;
        if (run_i && !stop_i) state_d = COUNT;
      end
      COUNT: begin
        if (clear_i) begin
          state_d = IDLE;
          bcd_d   = '0;
          ovf_d   = 1'b0;
        end else if (stop_i) begin
          // a tick coinciding with stop is dropped: bcd_q is the frozen result
          state_d = HOLD;
          done_d  = 1'b1;
          if (!ovf_q && (!best_valid_q || bcd_q < best_q)) begin
            best_d       = bcd_q;
            best_valid_d = 1'b1;
            new_best_d   = 1'b1;
          end
        end else if (!run_i) begin
          state_d = IDLE;
          bcd_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            if (bcd_q == 16'h9999) ovf_d = 1'b1;
            else                   bcd_d = bcd_inc(bcd_q);
          end
        end
      end
      HOLD: begin
        if (clear_i) begin
          state_d = IDLE;
          bcd_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    counting_d = (state_d == COUNT);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      bcd_q        <= 16'h0000;
      best_q       <= 16'h9999;
      best_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      done_q       <= 1'b0;
      new_best_q   <= 1'b0;
      counting_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      bcd_q        <= bcd_d;
      best_q       <= best_d;
      best_valid_q <= best_valid_d;
      ovf_q        <= ovf_d;
      done_q       <= done_d;
      new_best_q   <= new_best_d;
      counting_q   <= counting_d;
    end
  end

  assign bcd_o      = bcd_q;
  assign counting_o = counting_q;
  assign done_o     = done_q;
  assign overflow_o = ovf_q;
  assign best_bcd_o = best_q;
  assign new_best_o = new_best_q;

endmodule
